// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared pattern-mode and FSM state encodings for the pattern source
package axis_pkg;

    typedef enum logic [1:0] {
        MODE_INC   = 2'b00,
        MODE_CONST = 2'b01,
        MODE_DEC   = 2'b10,
        MODE_WALK  = 2'b11
    } mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

endpackage

// File: rtl/axis_pattern_step.sv
// rtl/axis_pattern_step.sv - combinational next-pattern-word function shared with the read-side checker
module axis_pattern_step
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  mode_t                 mode_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        unique case (mode_i)
            MODE_INC:   data_o = data_i + DATA_WIDTH'(1);
            MODE_CONST: data_o = data_i;
            MODE_DEC:   data_o = data_i - DATA_WIDTH'(1);
            MODE_WALK:  data_o = {data_i[DATA_WIDTH-2:0], data_i[DATA_WIDTH-1]};
            default:    data_o = data_i;
        endcase
    end

endmodule

// File: rtl/axis_pattern_source.sv
// rtl/axis_pattern_source.sv - AXI-Stream burst generator filling the memory wrapper with patterned words
module axis_pattern_source
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 12
) (
    input  logic                    m01_axis_aclk,
    input  logic                    m01_axis_aresetn,
    input  logic                    start,
    input  logic [LEN_WIDTH-1:0]    burst_len,
    input  logic [DATA_WIDTH-1:0]   seed,
    input  logic [1:0]              mode,
    output logic                    busy,
    output logic                    done,
    output logic [LEN_WIDTH-1:0]    beat_count,
    input  logic                    m01_axis_tready,
    output logic [DATA_WIDTH-1:0]   m01_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
    output logic                    m01_axis_tvalid,
    output logic                    m01_axis_tlast
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    state_t                  state_q;
    mode_t                   mode_q;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [LEN_WIDTH-1:0]    beat_count_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [DATA_WIDTH-1:0]   data_d;
    logic                    tvalid_q;
    logic                    tlast_q;
    logic                    done_q;
    logic                    transfer;
    logic                    next_is_last;

    assign transfer = tvalid_q & m01_axis_tready;

    // After this transfer the count becomes beat_count_q+1; that beat is last when it equals len-1.
    assign next_is_last = ({1'b0, beat_count_q} + (LEN_WIDTH + 1)'(2)) == {1'b0, len_q};

    axis_pattern_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .data_i (data_q),
        .mode_i (mode_q),
        .data_o (data_d)
    );

    always_ff @(posedge m01_axis_aclk or negedge m01_axis_aresetn) begin
        if (!m01_axis_aresetn) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_INC;
            len_q        <= '0;
            beat_count_q <= '0;
            data_q       <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && (burst_len != '0)) begin
                        state_q      <= ST_SEND;
                        len_q        <= burst_len;
                        mode_q       <= mode_t'(mode);
                        data_q       <= seed;
                        beat_count_q <= '0;
                        tvalid_q     <= 1'b1;
                        tlast_q      <= (burst_len == LEN_WIDTH'(1));
                    end
                end
                ST_SEND: begin
                    if (transfer) begin
                        beat_count_q <= beat_count_q + LEN_WIDTH'(1);
                        data_q       <= data_d;
                        if (tlast_q) begin
                            state_q  <= ST_IDLE;
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            done_q   <= 1'b1;
                        end else begin
                            tlast_q  <= next_is_last;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy            = (state_q == ST_SEND);
    assign done            = done_q;
    assign beat_count      = beat_count_q;
    assign m01_axis_tdata  = data_q;
    assign m01_axis_tstrb  = {STRB_WIDTH{tvalid_q}};
    assign m01_axis_tvalid = tvalid_q;
    assign m01_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_axis_pattern_source.sv
// tb/tb_axis_pattern_source.sv - self-checking bench for axis_pattern_source against a word-list model
module tb_axis_pattern_source;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] burst_len;
    logic [31:0] seed;
    logic [1:0]  mode;
    logic        busy;
    logic        done;
    logic [11:0] beat_count;
    logic        tready;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic        tvalid;
    logic        tlast;

    int checks = 0;
    int errors = 0;

    axis_pattern_source #(
        .DATA_WIDTH (32),
        .LEN_WIDTH  (12)
    ) dut (
        .m01_axis_aclk    (clk),
        .m01_axis_aresetn (rst_n),
        .start            (start),
        .burst_len        (burst_len),
        .seed             (seed),
        .mode             (mode),
        .busy             (busy),
        .done             (done),
        .beat_count       (beat_count),
        .m01_axis_tready  (tready),
        .m01_axis_tdata   (tdata),
        .m01_axis_tstrb   (tstrb),
        .m01_axis_tvalid  (tvalid),
        .m01_axis_tlast   (tlast)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Word sequence of a burst, written straight from the pattern rules.
    function automatic logic [31:0] model_next(input logic [31:0] d, input int m);
        logic [63:0] wide;
        case (m)
            0: return d + 32'd1;
            2: return d - 32'd1;
            3: begin
                wide = {32'd0, d} << 1;
                return wide[31:0] | wide[63:32];
            end
            default: return d;
        endcase
    endfunction

    // Entered at a negedge with the DUT idle (or in its done cycle); leaves at the negedge of the done cycle.
    // ready_mode: 0 = always ready, 1 = random, 2 = fixed 1,0,0,1,0,1 pattern.
    task automatic run_burst(input logic [31:0] sd, input int len, input int md,
                             input int ready_mode, input bit mid_start);
        logic [31:0] exp_q[$];
        logic [31:0] d;
        int pat[6] = '{1, 0, 0, 1, 0, 1};
        int idx = 0;
        int cyc = 0;
        int budget = len * 40 + 20;
        bit r;

        d = sd;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(d);
            d = model_next(d, md);
        end

        start = 1'b1; seed = sd; burst_len = 12'(len); mode = 2'(md);
        @(negedge clk);
        start = 1'b0; seed = $urandom; burst_len = 12'($urandom); mode = 2'($urandom);

        while (idx < len && cyc < budget) begin
            check("tvalid_in_burst", 32'(tvalid), 32'd1);
            check("busy_in_burst", 32'(busy), 32'd1);
            check("tdata", tdata, exp_q[idx]);
            check("tlast", 32'(tlast), 32'(idx == len - 1));
            check("tstrb", 32'(tstrb), 32'hF);
            check("beat_count_mid", 32'(beat_count), 32'(idx));
            case (ready_mode)
                0: r = 1'b1;
                1: r = 1'($urandom_range(0, 1));
                default: r = 1'(pat[cyc % 6]);
            endcase
            tready = r;
            if (mid_start && cyc == 1) begin
                start = 1'b1;
                burst_len = 12'($urandom_range(1, 9));
                seed = $urandom;
                mode = 2'($urandom);
            end
            @(posedge clk);
            if (r) idx++;
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        if (cyc >= budget) check("burst_timeout", 32'(idx), 32'(len));

        check("done_pulse", 32'(done), 32'd1);
        check("tvalid_after", 32'(tvalid), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
        check("tlast_after", 32'(tlast), 32'd0);
        check("beat_count_final", 32'(beat_count), 32'(len));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; burst_len = '0; seed = '0; mode = '0; tready = 1'b0;
        @(posedge clk);
        #1;
        check("rst_tvalid", 32'(tvalid), 32'd0);
        check("rst_tlast", 32'(tlast), 32'd0);
        check("rst_tdata", tdata, 32'd0);
        check("rst_tstrb", 32'(tstrb), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_beat_count", 32'(beat_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_burst(32'h55, 3, 0, 0, 1'b0);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);

        run_burst(32'h55, 3, 0, 2, 1'b0);
        @(negedge clk);

        run_burst(32'hFFFF_FFFF, 2, 0, 0, 1'b0);
        @(negedge clk);
        run_burst(32'h0000_0000, 2, 2, 0, 1'b0);
        @(negedge clk);
        run_burst(32'h8000_0000, 3, 3, 0, 1'b0);
        @(negedge clk);
        run_burst(32'hA5A5_0001, 4, 1, 1, 1'b0);
        @(negedge clk);

        start = 1'b1; burst_len = 12'd0; seed = 32'h1111; tready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("zero_len_tvalid", 32'(tvalid), 32'd0);
        check("zero_len_busy", 32'(busy), 32'd0);
        check("zero_len_done", 32'(done), 32'd0);
        @(negedge clk);
        check("zero_len_done_later", 32'(done), 32'd0);

        run_burst($urandom, 6, 0, 1, 1'b1);
        @(negedge clk);

        run_burst(32'h1234, 2, 0, 0, 1'b0);
        run_burst(32'h22, 1, 0, 0, 1'b0);
        @(negedge clk);

        start = 1'b1; burst_len = 12'd5; seed = 32'hABCD_0000; mode = 2'd0; tready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("pre_reset_count", 32'(beat_count), 32'd2);
        check("pre_reset_tdata", tdata, 32'hABCD_0002);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_tvalid", 32'(tvalid), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_count", 32'(beat_count), 32'd0);
        check("async_rst_tlast", 32'(tlast), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_burst(32'h0BAD_F00D, 4, 3, 1, 1'b0);
        @(negedge clk);

        for (int k = 0; k < 8; k++) begin
            run_burst($urandom, $urandom_range(1, 8), $urandom_range(0, 3), 1, 1'b0);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
